// File: rtl/tour_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tour_cmd_seq
// Description : Knight's-tour command sequencer. Walks the solver's list of
//               one-hot moves, splits each L-move into a vertical leg and a
//               horizontal leg with fanfare, and handshakes each leg with the
//               command processor. Transparent UART/BLE passthrough when idle.
// Revision    : 1.0 - initial release
// ============================================================================
module tour_cmd_seq #(
    parameter int NUM_MOVES = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic        clr_cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_VERT   = 3'd1;
    localparam logic [2:0] c_ST_WAIT_V = 3'd2;
    localparam logic [2:0] c_ST_HORZ   = 3'd3;
    localparam logic [2:0] c_ST_WAIT_H = 3'd4;

    localparam logic [4:0] c_LAST_INDX = 5'(NUM_MOVES - 1);
    localparam logic [7:0] c_RESP_ACK  = 8'hA5;
    localparam logic [7:0] c_RESP_DONE = 8'h5A;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [4:0]  r_mv_indx;
    logic [4:0]  w_mv_indx_nxt;
    logic [15:0] w_vert_leg;
    logic [15:0] w_horz_leg;
    logic        w_last;

    assign w_last  = (r_mv_indx == c_LAST_INDX);
    assign mv_indx = r_mv_indx;

    // Decode the one-hot move into its two legs; lowest set bit has priority
    always_comb begin
        w_vert_leg = 16'h4000;
        w_horz_leg = 16'h5000;
        if (move[0]) begin
            w_vert_leg = 16'h4002; w_horz_leg = 16'h5BF1;
        end else if (move[1]) begin
            w_vert_leg = 16'h4002; w_horz_leg = 16'h53F1;
        end else if (move[2]) begin
            w_vert_leg = 16'h4001; w_horz_leg = 16'h53F2;
        end else if (move[3]) begin
            w_vert_leg = 16'h47F1; w_horz_leg = 16'h53F2;
        end else if (move[4]) begin
            w_vert_leg = 16'h47F2; w_horz_leg = 16'h53F1;
        end else if (move[5]) begin
            w_vert_leg = 16'h47F2; w_horz_leg = 16'h5BF1;
        end else if (move[6]) begin
            w_vert_leg = 16'h47F1; w_horz_leg = 16'h5BF2;
        end else if (move[7]) begin
            w_vert_leg = 16'h4001; w_horz_leg = 16'h5BF2;
        end
    end

    // State and move-index registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_mv_indx <= 5'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_mv_indx <= w_mv_indx_nxt;
        end
    end

    // Next-state logic and state-decoded outputs
    always_comb begin
        w_state_nxt      = r_state;
        w_mv_indx_nxt    = r_mv_indx;
        cmd              = cmd_UART;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
        resp             = c_RESP_ACK;
        case (r_state)
            c_ST_IDLE: begin
                // Passthrough; the UART handshake still completes on a start cycle
                cmd              = cmd_UART;
                cmd_rdy          = cmd_rdy_UART;
                clr_cmd_rdy_UART = clr_cmd_rdy;
                if (start_tour) begin
                    w_mv_indx_nxt = 5'd0;
                    w_state_nxt   = c_ST_VERT;
                end
            end
            c_ST_VERT: begin
                cmd     = w_vert_leg;
                cmd_rdy = 1'b1;
                if (clr_cmd_rdy) w_state_nxt = c_ST_WAIT_V;
            end
            c_ST_WAIT_V: begin
                cmd = w_vert_leg;
                if (send_resp) w_state_nxt = c_ST_HORZ;
            end
            c_ST_HORZ: begin
                cmd     = w_horz_leg;
                cmd_rdy = 1'b1;
                if (clr_cmd_rdy) w_state_nxt = c_ST_WAIT_H;
            end
            c_ST_WAIT_H: begin
                cmd = w_horz_leg;
                if (w_last) resp = c_RESP_DONE;
                if (send_resp) begin
                    if (w_last) begin
                        w_state_nxt = c_ST_IDLE;
                    end else begin
                        w_mv_indx_nxt = r_mv_indx + 5'd1;
                        w_state_nxt   = c_ST_VERT;
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_tour_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_tour_cmd_seq
// Description : Directed self-checking bench for tour_cmd_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tour_cmd_seq;

    localparam int c_NUM_MOVES = 24;

    logic        clk;
    logic        rst_n;
    logic        start_tour;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic        clr_cmd_rdy_UART;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;

    int n_tests = 0;
    int n_fail  = 0;

    tour_cmd_seq #(.NUM_MOVES(c_NUM_MOVES)) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_tour       (start_tour),
        .move             (move),
        .mv_indx          (mv_indx),
        .cmd_UART         (cmd_UART),
        .cmd_rdy_UART     (cmd_rdy_UART),
        .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
        .cmd              (cmd),
        .cmd_rdy          (cmd_rdy),
        .clr_cmd_rdy      (clr_cmd_rdy),
        .send_resp        (send_resp),
        .resp             (resp)
    );

    // 50 MHz clock
    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance one edge, then settle before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Execute one full move at the current index from VERT back to the next VERT/IDLE
    task automatic do_move(input logic [7:0] mv, input logic [4:0] idx,
                           input logic [15:0] exp_v, input logic [15:0] exp_h);
        move = mv;
        #1;
        chk("vert_cmd", cmd, exp_v);
        chk("vert_rdy", {15'd0, cmd_rdy}, 16'd1);
        chk("vert_idx", {11'd0, mv_indx}, {11'd0, idx});
        clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
        #1;
        chk("waitv_rdy", {15'd0, cmd_rdy}, 16'd0);
        send_resp = 1'b1; tick(); send_resp = 1'b0;
        #1;
        chk("horz_cmd", cmd, exp_h);
        chk("horz_rdy", {15'd0, cmd_rdy}, 16'd1);
        clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
        #1;
        chk("waith_rdy", {15'd0, cmd_rdy}, 16'd0);
        chk("waith_resp", {8'd0, resp}, (idx == 5'(c_NUM_MOVES - 1)) ? 16'h005A : 16'h00A5);
        send_resp = 1'b1; tick(); send_resp = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        start_tour   = 1'b0;
        move         = 8'h00;
        cmd_UART     = 16'h1234;
        cmd_rdy_UART = 1'b0;
        clr_cmd_rdy  = 1'b0;
        send_resp    = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        #1;

        // Reset state
        chk("rst_cmd", cmd, 16'h1234);
        chk("rst_rdy", {15'd0, cmd_rdy}, 16'd0);
        chk("rst_clr_uart", {15'd0, clr_cmd_rdy_UART}, 16'd0);
        chk("rst_resp", {8'd0, resp}, 16'h00A5);
        chk("rst_idx", {11'd0, mv_indx}, 16'd0);

        // Idle passthrough
        cmd_UART = 16'h2000; cmd_rdy_UART = 1'b1; #1;
        chk("pt_cmd", cmd, 16'h2000);
        chk("pt_rdy", {15'd0, cmd_rdy}, 16'd1);
        clr_cmd_rdy = 1'b1; #1;
        chk("pt_clr", {15'd0, clr_cmd_rdy_UART}, 16'd1);
        tick();
        clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0;

        // Tour start with move 8'h01; first leg visible the cycle after start
        move = 8'h01;
        start_tour = 1'b1; tick(); start_tour = 1'b0;
        #1;
        chk("start_cmd", cmd, 16'h4002);
        chk("start_rdy", {15'd0, cmd_rdy}, 16'd1);
        // send_resp in VERT is ignored
        send_resp = 1'b1; tick(); send_resp = 1'b0; #1;
        chk("vert_ign_cmd", cmd, 16'h4002);
        chk("vert_ign_rdy", {15'd0, cmd_rdy}, 16'd1);
        // UART command arrives mid-tour and must be held off
        cmd_UART = 16'h3000; cmd_rdy_UART = 1'b1;
        clr_cmd_rdy = 1'b1; #1;
        chk("tour_clr_uart", {15'd0, clr_cmd_rdy_UART}, 16'd0);
        chk("tour_cmd_hold", cmd, 16'h4002);
        tick(); clr_cmd_rdy = 1'b0; #1;
        chk("wv_rdy", {15'd0, cmd_rdy}, 16'd0);
        chk("wv_cmd", cmd, 16'h4002);
        // start_tour during the tour is ignored
        start_tour = 1'b1; tick(); start_tour = 1'b0; #1;
        chk("wv_start_ign", {15'd0, cmd_rdy}, 16'd0);
        send_resp = 1'b1; tick(); send_resp = 1'b0; #1;
        chk("h0_cmd", cmd, 16'h5BF1);
        chk("h0_rdy", {15'd0, cmd_rdy}, 16'd1);
        clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0; #1;
        chk("wh0_resp", {8'd0, resp}, 16'h00A5);
        send_resp = 1'b1; tick(); send_resp = 1'b0; #1;
        chk("adv_idx", {11'd0, mv_indx}, 16'd1);
        chk("adv_rdy", {15'd0, cmd_rdy}, 16'd1);
        chk("adv_resp", {8'd0, resp}, 16'h00A5);

        // Decode sweep, including illegal values
        do_move(8'h08, 5'd1, 16'h47F1, 16'h53F2);
        do_move(8'h40, 5'd2, 16'h47F1, 16'h5BF2);
        do_move(8'h0C, 5'd3, 16'h4001, 16'h53F2);
        do_move(8'h00, 5'd4, 16'h4000, 16'h5000);
        do_move(8'h02, 5'd5, 16'h4002, 16'h53F1);
        do_move(8'h10, 5'd6, 16'h47F2, 16'h53F1);
        do_move(8'h20, 5'd7, 16'h47F2, 16'h5BF1);
        do_move(8'h80, 5'd8, 16'h4001, 16'h5BF2);
        do_move(8'h04, 5'd9, 16'h4001, 16'h53F2);
        for (int i = 10; i < c_NUM_MOVES; i++) begin
            do_move(8'h80, 5'(i), 16'h4001, 16'h5BF2);
        end

        // Tour end: back in IDLE, held UART command forwarded
        #1;
        chk("end_cmd", cmd, 16'h3000);
        chk("end_rdy", {15'd0, cmd_rdy}, 16'd1);
        chk("end_resp", {8'd0, resp}, 16'h00A5);
        chk("end_idx", {11'd0, mv_indx}, 16'd23);
        clr_cmd_rdy = 1'b1; #1;
        chk("end_clr_uart", {15'd0, clr_cmd_rdy_UART}, 16'd1);
        tick(); clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0;

        // Abort: restart, advance one move, reset in HORZ
        move = 8'h01;
        start_tour = 1'b1; tick(); start_tour = 1'b0; #1;
        chk("restart_idx", {11'd0, mv_indx}, 16'd0);
        do_move(8'h01, 5'd0, 16'h4002, 16'h5BF1);
        #1;
        clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
        send_resp   = 1'b1; tick(); send_resp   = 1'b0; #1;
        chk("ab_horz_cmd", cmd, 16'h5BF1);
        chk("ab_horz_idx", {11'd0, mv_indx}, 16'd1);
        rst_n = 1'b0; tick(); rst_n = 1'b1; #1;
        chk("ab_rdy", {15'd0, cmd_rdy}, 16'd0);
        chk("ab_idx", {11'd0, mv_indx}, 16'd0);
        chk("ab_cmd", cmd, 16'h3000);
        tick(); tick(); #1;
        chk("ab_stay_rdy", {15'd0, cmd_rdy}, 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tour_cmd_seq.md
Name: tour_cmd_seq

Overview:
- Sequencer that drives the command processor during an autonomous knight's tour.
- Walks a pre-solved list of one-hot knight moves from the tour solver, indexed by `mv_indx`.
- Splits each L-shaped move into two move commands, a vertical leg then a horizontal leg with fanfare, and handshakes each leg through `cmd_rdy`/`clr_cmd_rdy`/`send_resp`.
- When no tour is active it is a transparent mux, so BLE/UART commands reach the command processor unchanged.

Parameters:
- NUM_MOVES, 24: number of knight moves in a tour (5x5 board); last index is NUM_MOVES-1.

Ports:
- clk  in  1  50MHz system clock
- rst_n  in  1  reset, synchronous active-low
- start_tour  in  1  pulse from the tour solver: solution ready, begin sequencing
- move  in  8  one-hot knight move for the current `mv_indx`, from the solver move memory
- mv_indx  out  5  index of the move being executed
- cmd_UART  in  16  command from the UART/BLE wrapper
- cmd_rdy_UART  in  1  UART command valid
- clr_cmd_rdy_UART  out  1  consume strobe back to the UART wrapper
- cmd  out  16  command to the command processor
- cmd_rdy  out  1  `cmd` valid to the command processor
- clr_cmd_rdy  in  1  command processor consumed `cmd`
- send_resp  in  1  command processor finished the current command
- resp  out  8  response byte for the UART wrapper

Behaviour:
- Clock and reset:
  - Single clock `clk`.
  - `rst_n` is synchronous and active-low; it is sampled only on posedge `clk`.
  - Reset forces state=IDLE and `mv_indx`=0.
  - Resulting outputs: `cmd_rdy`=0, `clr_cmd_rdy_UART`=0, `resp`=8'hA5, `cmd`=`cmd_UART`.
  - A reset asserted mid-tour aborts the tour at the next edge; no further commands are issued.
- Command format:
  - `cmd[15:12]` opcode: 4'h4 = move, 4'h5 = move with fanfare.
  - `cmd[11:4]` heading: N=8'h00, W=8'h3F, S=8'h7F, E=8'hBF.
  - `cmd[3:0]` number of squares.
- Move decode (x positive east, y positive north), as vertical leg / horizontal leg:
  - bit0 (+1,+2): 16'h4002 / 16'h5BF1
  - bit1 (-1,+2): 16'h4002 / 16'h53F1
  - bit2 (-2,+1): 16'h4001 / 16'h53F2
  - bit3 (-2,-1): 16'h47F1 / 16'h53F2
  - bit4 (-1,-2): 16'h47F2 / 16'h53F1
  - bit5 (+1,-2): 16'h47F2 / 16'h5BF1
  - bit6 (+2,-1): 16'h47F1 / 16'h5BF2
  - bit7 (+2,+1): 16'h4001 / 16'h5BF2
- Illegal `move` values:
  - Multiple bits set: lowest set bit wins.
  - `move`=0: legs are 16'h4000 and 16'h5000.
- State machine, next-state registered, outputs combinational from state:
  - IDLE:
    - `cmd`=`cmd_UART`, `cmd_rdy`=`cmd_rdy_UART`, `clr_cmd_rdy_UART`=`clr_cmd_rdy`.
    - On `start_tour`: `mv_indx`<=0, go to VERT.
  - VERT:
    - `cmd`=vertical leg, `cmd_rdy`=1.
    - On `clr_cmd_rdy`: go to WAIT_V.
  - WAIT_V:
    - `cmd` still shows the vertical leg; `cmd_rdy`=0.
    - On `send_resp`: go to HORZ.
  - HORZ:
    - `cmd`=horizontal leg, `cmd_rdy`=1.
    - On `clr_cmd_rdy`: go to WAIT_H.
  - WAIT_H:
    - `cmd_rdy`=0.
    - On `send_resp` with `mv_indx`==NUM_MOVES-1: go to IDLE.
    - On `send_resp` otherwise: `mv_indx`<=`mv_indx`+1, go to VERT.
- Latency:
  - `cmd_rdy` rises the cycle after `start_tour` is sampled.
  - `cmd_rdy` for the next leg rises the cycle after the `send_resp` edge.
- Arbitration:
  - In any non-IDLE state, `cmd_rdy_UART` is ignored and `clr_cmd_rdy_UART`=0.
  - A pending UART command stays pending and is passed through on return to IDLE.
  - `start_tour` outside IDLE is ignored.
  - `start_tour` coincident with `cmd_rdy_UART` in IDLE: the UART handshake passes through that cycle and the tour still starts.
- `resp`:
  - 8'h5A while in WAIT_H with `mv_indx`==NUM_MOVES-1 (final response).
  - 8'hA5 otherwise, including IDLE passthrough.
- `send_resp` arriving in VERT or HORZ (before `clr_cmd_rdy`) is ignored.
- `mv_indx` never exceeds NUM_MOVES-1 and has no wrap-around.

Test Plan:
- Reset then idle passthrough: `cmd_UART`=16'h2000 with `cmd_rdy_UART`=1 -> `cmd`=16'h2000, `cmd_rdy`=1; pulse `clr_cmd_rdy` -> `clr_cmd_rdy_UART`=1 the same cycle.
- Tour start with `move`=8'h01:
  - `start_tour` pulse -> next cycle `cmd`=16'h4002, `cmd_rdy`=1.
  - `clr_cmd_rdy` -> `cmd_rdy`=0; `send_resp` -> `cmd`=16'h5BF1, `cmd_rdy`=1.
- Advance: after the horizontal leg's `send_resp` with `mv_indx`=0 -> `mv_indx`=1, state VERT, `resp`=8'hA5 throughout.
- Decode sweep: apply `move`=8'h08 -> legs 16'h47F1 / 16'h53F2; `move`=8'h40 -> legs 16'h47F1 / 16'h5BF2; `move`=8'h0C -> behaves as 8'h04.
- Tour end: at `mv_indx`=23 in WAIT_H, `resp`=8'h5A; on `send_resp` -> IDLE, a UART command held during the tour is now forwarded.
- Abort: assert `rst_n`=0 for one edge in HORZ -> `cmd_rdy`=0, `mv_indx`=0, IDLE; a `start_tour` issued during the tour is ignored.
